ave8_stream_ctrl: RTL and testbench



---
 rtl/ave8_stream_ctrl.sv | 95 +++++++++
 tb/tb_ave8_stream_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ave8_stream_ctrl.sv
// rtl/ave8_stream_ctrl.sv - 8-tap moving-average stream controller with running sum
module ave8_stream_ctrl #(
   parameter int DATA_W       = 8,
   parameter bit EMIT_PARTIAL = 1'b1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              avg_valid,
   output logic [DATA_W-1:0] avg_data,
   input  logic              avg_ready,
   output logic [3:0]        fill_cnt,
   output logic              window_full
);

   localparam int SUM_W = DATA_W + 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UPD  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] win_buf [8];
   logic [2:0]        wptr;
   logic [SUM_W-1:0]  sum;
   logic [DATA_W-1:0] sample;
   logic [SUM_W-1:0]  sum_next;
   logic [3:0]        fill_next;

   // Accept only in IDLE; reset and clear block acceptance in the same cycle.
   assign in_ready = (state == IDLE) && !RESET && !clear;

   // Running sum: add the newest sample, drop the one it overwrites. The
   // intermediate may wrap past SUM_W bits, but the final value always fits.
   always_comb begin
      sum_next  = sum + SUM_W'(sample) - SUM_W'(win_buf[wptr]);
      fill_next = (fill_cnt == 4'd8) ? 4'd8 : fill_cnt + 4'd1;
   end

   // Sequencing FSM with window storage and registered result outputs.
   always_ff @(posedge CLOCK) begin
      if (RESET || clear) begin
         state       <= IDLE;
         wptr        <= 3'd0;
         sum         <= '0;
         sample      <= '0;
         fill_cnt    <= 4'd0;
         window_full <= 1'b0;
         avg_valid   <= 1'b0;
         avg_data    <= '0;
         for (int i = 0; i < 8; i++) begin
            win_buf[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sample <= in_data;
                  state  <= UPD;
               end
            end
            UPD: begin
               win_buf[wptr] <= sample;
               sum           <= sum_next;
               wptr          <= wptr + 3'd1;
               fill_cnt      <= fill_next;
               window_full   <= (fill_next == 4'd8);
               avg_data      <= sum_next[SUM_W-1:3];
               if (EMIT_PARTIAL || (fill_next == 4'd8)) begin
                  avg_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  state <= IDLE;
               end
            end
            OUT: begin
               if (avg_ready) begin
                  avg_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               avg_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ave8_stream_ctrl.sv
// tb/tb_ave8_stream_ctrl.sv - directed self-checking bench for ave8_stream_ctrl
module tb_ave8_stream_ctrl;

   logic       CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       clear = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_ready;
   logic       avg_valid;
   logic [7:0] avg_data;
   logic       avg_ready = 1'b1;
   logic [3:0] fill_cnt;
   logic       window_full;

   logic       clear0 = 1'b0;
   logic       in_valid0 = 1'b0;
   logic [7:0] in_data0 = 8'd0;
   logic       in_ready0;
   logic       avg_valid0;
   logic [7:0] avg_data0;
   logic       avg_ready0 = 1'b1;
   logic [3:0] fill_cnt0;
   logic       window_full0;

   int chk_total = 0;
   int chk_pass  = 0;

   always #5 CLOCK = ~CLOCK;

   ave8_stream_ctrl #(.DATA_W(8), .EMIT_PARTIAL(1'b1)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .clear(clear),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .avg_valid(avg_valid), .avg_data(avg_data), .avg_ready(avg_ready),
      .fill_cnt(fill_cnt), .window_full(window_full)
   );

   ave8_stream_ctrl #(.DATA_W(8), .EMIT_PARTIAL(1'b0)) dut0 (
      .CLOCK(CLOCK), .RESET(RESET), .clear(clear0),
      .in_valid(in_valid0), .in_data(in_data0), .in_ready(in_ready0),
      .avg_valid(avg_valid0), .avg_data(avg_data0), .avg_ready(avg_ready0),
      .fill_cnt(fill_cnt0), .window_full(window_full0)
   );

   task automatic push(input logic [7:0] d, input logic [7:0] exp_avg, input logic [3:0] exp_fill, input string nm);
      int n;
      @(negedge CLOCK);
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 8) begin
         @(negedge CLOCK);
         n++;
      end
      chk_total++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready got %b want 1", nm, in_ready); else chk_pass++;
      @(posedge CLOCK);
      @(negedge CLOCK);
      in_valid = 1'b0;
      chk_total++;
      if (avg_valid !== 1'b0) $display("FAIL %s upd_avg_valid got %b want 0", nm, avg_valid); else chk_pass++;
      @(negedge CLOCK);
      chk_total++;
      if (avg_valid !== 1'b1) $display("FAIL %s avg_valid got %b want 1", nm, avg_valid); else chk_pass++;
      chk_total++;
      if (avg_data !== exp_avg) $display("FAIL %s avg_data got %0d want %0d", nm, avg_data, exp_avg); else chk_pass++;
      chk_total++;
      if (fill_cnt !== exp_fill) $display("FAIL %s fill_cnt got %0d want %0d", nm, fill_cnt, exp_fill); else chk_pass++;
      chk_total++;
      if (window_full !== (exp_fill == 4'd8)) $display("FAIL %s window_full got %b want %b", nm, window_full, exp_fill == 4'd8); else chk_pass++;
      if (avg_ready) begin
         @(negedge CLOCK);
         chk_total++;
         if (avg_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s release got valid=%b ready=%b want valid=0 ready=1", nm, avg_valid, in_ready);
         else chk_pass++;
      end
   endtask

   task automatic push_np(input logic [7:0] d, input logic emit, input logic [7:0] exp_avg, input logic [3:0] exp_fill);
      int n;
      @(negedge CLOCK);
      in_data0  = d;
      in_valid0 = 1'b1;
      n = 0;
      while (!in_ready0 && n < 8) begin
         @(negedge CLOCK);
         n++;
      end
      chk_total++;
      if (in_ready0 !== 1'b1) $display("FAIL np_in_ready[%0d] got %b want 1", d, in_ready0); else chk_pass++;
      @(posedge CLOCK);
      @(negedge CLOCK);
      in_valid0 = 1'b0;
      @(negedge CLOCK);
      chk_total++;
      if (avg_valid0 !== emit) $display("FAIL np_avg_valid[%0d] got %b want %b", d, avg_valid0, emit); else chk_pass++;
      chk_total++;
      if (fill_cnt0 !== exp_fill) $display("FAIL np_fill[%0d] got %0d want %0d", d, fill_cnt0, exp_fill); else chk_pass++;
      if (emit) begin
         chk_total++;
         if (avg_data0 !== exp_avg) $display("FAIL np_avg_data[%0d] got %0d want %0d", d, avg_data0, exp_avg); else chk_pass++;
         @(negedge CLOCK);
         chk_total++;
         if (avg_valid0 !== 1'b0) $display("FAIL np_release[%0d] got %b want 0", d, avg_valid0); else chk_pass++;
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      @(negedge CLOCK);
      @(negedge CLOCK);
      chk_total++;
      if (avg_valid !== 1'b0) $display("FAIL rst_avg_valid got %b want 0", avg_valid); else chk_pass++;
      chk_total++;
      if (avg_data !== 8'd0) $display("FAIL rst_avg_data got %0d want 0", avg_data); else chk_pass++;
      chk_total++;
      if (fill_cnt !== 4'd0) $display("FAIL rst_fill_cnt got %0d want 0", fill_cnt); else chk_pass++;
      chk_total++;
      if (window_full !== 1'b0) $display("FAIL rst_window_full got %b want 0", window_full); else chk_pass++;
      chk_total++;
      if (in_ready !== 1'b0) $display("FAIL rst_in_ready_during got %b want 0", in_ready); else chk_pass++;
      RESET = 1'b0;
      @(negedge CLOCK);
      chk_total++;
      if (in_ready !== 1'b1) $display("FAIL rst_in_ready_after got %b want 1", in_ready); else chk_pass++;
   endtask

   task automatic test_partial();
      for (int k = 1; k <= 8; k++) begin
         push(8'd8, 8'(k), 4'(k), "partial8");
      end
      push(8'd16, 8'd9, 4'd8, "partial16");
   endtask

   task automatic test_clear_pulse();
      @(negedge CLOCK);
      clear = 1'b1;
      @(negedge CLOCK);
      clear = 1'b0;
   endtask

   task automatic test_saturate();
      test_clear_pulse();
      for (int k = 1; k <= 8; k++) begin
         push(8'd255, 8'((255 * k) / 8), 4'(k), "sat255");
      end
      push(8'd0, 8'd223, 4'd8, "sat0");
   endtask

   task automatic test_backpressure();
      @(negedge CLOCK);
      avg_ready = 1'b0;
      in_data   = 8'd8;
      in_valid  = 1'b1;
      chk_total++;
      if (in_ready !== 1'b1) $display("FAIL bp_accept got %b want 1", in_ready); else chk_pass++;
      @(negedge CLOCK);
      in_data = 8'd100;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLOCK);
         chk_total++;
         if (avg_valid !== 1'b1 || avg_data !== 8'd192 || in_ready !== 1'b0)
            $display("FAIL bp_hold[%0d] got valid=%b data=%0d ready=%b want 1/192/0", c, avg_valid, avg_data, in_ready);
         else chk_pass++;
      end
      avg_ready = 1'b1;
      @(negedge CLOCK);
      in_valid = 1'b0;
      chk_total++;
      if (avg_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release got valid=%b ready=%b want 0/1", avg_valid, in_ready);
      else chk_pass++;
      push(8'd100, 8'd172, 4'd8, "bp_after");
   endtask

   task automatic test_clear();
      @(negedge CLOCK);
      avg_ready = 1'b0;
      in_data   = 8'd50;
      in_valid  = 1'b1;
      @(negedge CLOCK);
      in_data = 8'd77;
      @(negedge CLOCK);
      chk_total++;
      if (avg_valid !== 1'b1 || avg_data !== 8'd147)
         $display("FAIL clr_pre got valid=%b data=%0d want 1/147", avg_valid, avg_data);
      else chk_pass++;
      clear = 1'b1;
      @(negedge CLOCK);
      clear    = 1'b0;
      in_valid = 1'b0;
      avg_ready = 1'b1;
      chk_total++;
      if (avg_valid !== 1'b0 || fill_cnt !== 4'd0 || window_full !== 1'b0 || avg_data !== 8'd0)
         $display("FAIL clr_state got valid=%b fill=%0d full=%b data=%0d want 0/0/0/0", avg_valid, fill_cnt, window_full, avg_data);
      else chk_pass++;
      push(8'd40, 8'd5, 4'd1, "clr_after");
   endtask

   task automatic test_no_partial();
      for (int k = 1; k <= 7; k++) begin
         push_np(8'(k), 1'b0, 8'd0, 4'(k));
      end
      push_np(8'd8, 1'b1, 8'd4, 4'd8);
      chk_total++;
      if (window_full0 !== 1'b1) $display("FAIL np_window_full got %b want 1", window_full0); else chk_pass++;
      push_np(8'd9, 1'b1, 8'd5, 4'd8);
   endtask

   initial begin
      test_reset();
      test_partial();
      test_saturate();
      test_backpressure();
      test_clear();
      test_no_partial();
      $display("%0d/%0d checks passed", chk_pass, chk_total);
      $finish;
   end

endmodule
